// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parameterised SPI slave with TX holding register, RX word output and error pulses
module spi_slave_param #(
   parameter int          DATA_W     = 8,
   parameter int          CPOL       = 0,
   parameter int          CPHA       = 0,
   parameter int          MSB_FIRST  = 1,
   parameter logic [31:0] DEFAULT_TX = 32'h10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk_in,
   input  logic              mosi_in,
   input  logic              ss_n_in,
   input  logic [DATA_W-1:0] tx_data_in,
   input  logic              tx_load_in,
   output logic              tx_ready_out,
   output logic [DATA_W-1:0] rx_data_out,
   output logic              rx_valid_out,
   output logic              tx_underrun_out,
   output logic              frame_error_out,
   output logic              miso_out
);

   localparam int              CW        = $clog2(DATA_W);
   localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_W - 1);
   localparam logic [DATA_W-1:0] DEF_WORD = DEFAULT_TX[DATA_W-1:0];
   localparam logic            SCLK_IDLE = (CPOL != 0);

   typedef enum logic {ST_IDLE, ST_FRAME} state_t;
   state_t state, state_next;

   logic [1:0]        sclk_sync, mosi_sync, ss_sync;
   logic              sclk_q, ss_q;
   logic              sclk_s, mosi_s, ss_s;
   logic              sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic              ss_fall, ss_rise;
   logic              frame_start, frame_end, sample_evt, shift_evt;
   logic              word_done, boundary_load, tx_shift_evt, commit;
   logic              load_ok, consume, underrun_evt;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] rx_shift, rx_next, tx_shift, hold_reg;
   logic              hold_full, pend, pend_def;

   assign sclk_s = sclk_sync[1];
   assign mosi_s = mosi_sync[1];
   assign ss_s   = ss_sync[1];

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      sample_evt  = 1'b0;
      shift_evt   = 1'b0;
      sclk_rise   = sclk_s & ~sclk_q;
      sclk_fall   = ~sclk_s & sclk_q;
      lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
      trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
      ss_fall     = ss_q & ~ss_s;
      ss_rise     = ~ss_q & ss_s;
      case (state)
         ST_IDLE: begin
            if (ss_fall) begin
               frame_start = 1'b1;
               state_next  = ST_FRAME;
            end
         end
         ST_FRAME: begin
            if (ss_rise) begin
               frame_end  = 1'b1;
               state_next = ST_IDLE;
            end else begin
               sample_evt = (CPHA != 0) ? trail_edge : lead_edge;
               shift_evt  = (CPHA != 0) ? lead_edge  : trail_edge;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Word-boundary loads are tentative: holding consumption and the underrun pulse
   // are committed at the first sample edge of the new word, so the trailing load
   // at the end of a frame (a word never clocked out) has no side effects.
   always_comb begin
      word_done     = sample_evt && (bit_cnt == LAST_BIT);
      boundary_load = (CPHA != 0) ? word_done : (shift_evt && (bit_cnt == '0));
      tx_shift_evt  = shift_evt && !boundary_load && ((CPHA == 0) || (bit_cnt != '0));
      commit        = sample_evt && pend;
      load_ok       = tx_load_in && !hold_full;
      consume       = (frame_start && hold_full) || (commit && !pend_def);
      underrun_evt  = (frame_start && !hold_full) || (commit && pend_def);
      rx_next       = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_s}
                                       : {mosi_s, rx_shift[DATA_W-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync       <= {2{SCLK_IDLE}};
         sclk_q          <= SCLK_IDLE;
         mosi_sync       <= 2'b00;
         ss_sync         <= 2'b11;
         ss_q            <= 1'b1;
         bit_cnt         <= '0;
         rx_shift        <= '0;
         tx_shift        <= '0;
         hold_reg        <= '0;
         hold_full       <= 1'b0;
         pend            <= 1'b0;
         pend_def        <= 1'b0;
         rx_data_out     <= '0;
         rx_valid_out    <= 1'b0;
         tx_underrun_out <= 1'b0;
         frame_error_out <= 1'b0;
      end else begin
         sclk_sync       <= {sclk_sync[0], sclk_in};
         sclk_q          <= sclk_s;
         mosi_sync       <= {mosi_sync[0], mosi_in};
         ss_sync         <= {ss_sync[0], ss_n_in};
         ss_q            <= ss_s;
         rx_valid_out    <= 1'b0;
         tx_underrun_out <= underrun_evt;
         frame_error_out <= frame_end && (bit_cnt != '0);

         if (frame_start || frame_end) bit_cnt <= '0;
         else if (word_done)           bit_cnt <= '0;
         else if (sample_evt)          bit_cnt <= bit_cnt + 1'b1;

         if (frame_start)     rx_shift <= '0;
         else if (sample_evt) rx_shift <= rx_next;

         if (word_done) begin
            rx_data_out  <= rx_next;
            rx_valid_out <= 1'b1;
         end

         if (frame_start || boundary_load)
            tx_shift <= hold_full ? hold_reg : DEF_WORD;
         else if (tx_shift_evt)
            tx_shift <= (MSB_FIRST != 0) ? (tx_shift << 1) : (tx_shift >> 1);

         if (frame_start || frame_end) begin
            pend <= 1'b0;
         end else if (boundary_load) begin
            pend     <= 1'b1;
            pend_def <= !hold_full;
         end else if (commit) begin
            pend <= 1'b0;
         end

         if (load_ok) begin
            hold_reg  <= tx_data_in;
            hold_full <= 1'b1;
         end else if (consume) begin
            hold_full <= 1'b0;
         end
      end
   end

   assign tx_ready_out = !hold_full;
   assign miso_out     = (state == ST_FRAME) &&
                         ((MSB_FIRST != 0) ? tx_shift[DATA_W-1] : tx_shift[0]);

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - table-driven and randomised bench for spi_slave_param
module tb_spi_slave_param;

   localparam int H = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [4:0]       sclk, ss_n, mosi, tx_load;
   logic [11:0]      tx_data [5];
   wire  [4:0]       miso, rx_valid, tx_ready, underrun, ferr;
   wire  [11:0]      rx_w [5];
   wire  [7:0]       rx_data0;

   spi_slave_param u_d0 (
      .clk(clk), .reset(reset), .sclk_in(sclk[0]), .mosi_in(mosi[0]), .ss_n_in(ss_n[0]),
      .tx_data_in(tx_data[0][7:0]), .tx_load_in(tx_load[0]), .tx_ready_out(tx_ready[0]),
      .rx_data_out(rx_data0), .rx_valid_out(rx_valid[0]), .tx_underrun_out(underrun[0]),
      .frame_error_out(ferr[0]), .miso_out(miso[0])
   );
   assign rx_w[0] = {4'h0, rx_data0};

   // instances 1..4: CPOL/CPHA = 00, 01, 10, 11, 12-bit LSB first
   for (genvar g = 1; g < 5; g++) begin : g_m
      spi_slave_param #(.DATA_W(12), .CPOL((g - 1) / 2), .CPHA((g - 1) % 2), .MSB_FIRST(0)) u_d (
         .clk(clk), .reset(reset), .sclk_in(sclk[g]), .mosi_in(mosi[g]), .ss_n_in(ss_n[g]),
         .tx_data_in(tx_data[g]), .tx_load_in(tx_load[g]), .tx_ready_out(tx_ready[g]),
         .rx_data_out(rx_w[g]), .rx_valid_out(rx_valid[g]), .tx_underrun_out(underrun[g]),
         .frame_error_out(ferr[g]), .miso_out(miso[g])
      );
   end

   int          rxv_cnt [5] = '{default: 0};
   int          und_cnt [5] = '{default: 0};
   int          fe_cnt  [5] = '{default: 0};
   logic [11:0] rx_log  [5][16];

   always @(negedge clk) begin
      for (int k = 0; k < 5; k++) begin
         if (rx_valid[k]) begin
            rx_log[k][rxv_cnt[k] % 16] = rx_w[k];
            rxv_cnt[k]++;
         end
         if (underrun[k]) und_cnt[k]++;
         if (ferr[k]) fe_cnt[k]++;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int width_of(input int k); return (k == 0) ? 8 : 12; endfunction
   function automatic logic cpol_of(input int k); return (k == 0) ? 1'b0 : ((k - 1) / 2 != 0); endfunction
   function automatic logic cpha_of(input int k); return (k == 0) ? 1'b0 : ((k - 1) % 2 != 0); endfunction
   function automatic logic [11:0] mask(input int k, input logic [11:0] v);
      return (k == 0) ? {4'h0, v[7:0]} : v;
   endfunction

   task automatic wait_clk(input int n); repeat (n) @(negedge clk); endtask

   logic [11:0] mw [3];
   logic [11:0] miso_got [3];
   logic [11:0] em [3];

   task automatic xfer_bit(input int k, input logic b, output logic m);
      logic cp;
      cp = cpol_of(k);
      if (!cpha_of(k)) begin
         mosi[k] = b;  wait_clk(H);
         m = miso[k];  sclk[k] = ~cp; wait_clk(H);
         sclk[k] = cp;
      end else begin
         sclk[k] = ~cp; mosi[k] = b; wait_clk(H);
         m = miso[k];   sclk[k] = cp; wait_clk(H);
      end
   endtask

   task automatic frame(input int k, input int nw, input int lim);
      int total, n, bi;
      logic m;
      total = 0;
      n = width_of(k);
      ss_n[k] = 1'b0;
      wait_clk(8);
      for (int j = 0; j < nw; j++) begin
         miso_got[j] = '0;
         for (int b = 0; b < n; b++) begin
            if (lim == 0 || total < lim) begin
               bi = (k == 0) ? n - 1 - b : b;
               xfer_bit(k, mw[j][bi], m);
               miso_got[j][bi] = m;
               total++;
            end
         end
      end
      wait_clk(H);
      ss_n[k] = 1'b1;
      wait_clk(8);
   endtask

   task automatic load(input int k, input logic [11:0] v);
      tx_data[k] = v;
      tx_load[k] = 1'b1;
      wait_clk(1);
      tx_load[k] = 1'b0;
   endtask

   task automatic frame_check(input string nm, input int k, input int nw, input logic ld,
                              input logic [11:0] tx, input int eund);
      int rb, ub, fb;
      rb = rxv_cnt[k]; ub = und_cnt[k]; fb = fe_cnt[k];
      if (ld) load(k, tx);
      frame(k, nw, 0);
      check({nm, " rx_valid count"}, rxv_cnt[k] - rb, nw);
      for (int j = 0; j < nw; j++) begin
         check($sformatf("%s rx word %0d", nm, j), rx_log[k][(rb + j) % 16], mask(k, mw[j]));
         check($sformatf("%s miso word %0d", nm, j), miso_got[j], em[j]);
      end
      check({nm, " underrun count"}, und_cnt[k] - ub, eund);
      check({nm, " frame_error count"}, fe_cnt[k] - fb, 0);
      check({nm, " tx_ready after"}, tx_ready[k], 1);
      check({nm, " rx_data hold"}, rx_w[k], mask(k, mw[nw - 1]));
   endtask

   typedef struct {
      int          inst;
      logic        ld;
      logic [11:0] tx;
      int          nw;
      logic [11:0] w0, w1;
      logic [11:0] m0, m1;
      int          und;
   } vec_t;

   vec_t vt [7];

   initial begin
      int rb, ub, fb, k, nw;
      logic ld, m;
      logic [11:0] tx;

      vt[0] = '{0, 1'b0, 12'h000, 1, 12'h0A5, 12'h000, 12'h010, 12'h000, 1};
      vt[1] = '{0, 1'b1, 12'h03C, 2, 12'h012, 12'h034, 12'h03C, 12'h010, 1};
      vt[2] = '{1, 1'b1, 12'hABC, 1, 12'hABC, 12'h000, 12'hABC, 12'h000, 0};
      vt[3] = '{2, 1'b1, 12'hABC, 1, 12'hABC, 12'h000, 12'hABC, 12'h000, 0};
      vt[4] = '{3, 1'b1, 12'hABC, 1, 12'hABC, 12'h000, 12'hABC, 12'h000, 0};
      vt[5] = '{4, 1'b1, 12'hABC, 1, 12'hABC, 12'h000, 12'hABC, 12'h000, 0};
      vt[6] = '{3, 1'b0, 12'h000, 2, 12'h5A3, 12'h0F0, 12'h010, 12'h010, 2};

      reset = 1'b1;
      ss_n = '1; mosi = '0; tx_load = '0;
      for (int i = 0; i < 5; i++) begin
         sclk[i] = cpol_of(i);
         tx_data[i] = '0;
      end
      wait_clk(4);
      check("reset rx_data", rx_w[0], 0);
      check("reset rx_valid", rx_valid, 0);
      check("reset miso", miso, 0);
      check("reset tx_ready", tx_ready, 5'h1F);
      check("reset underrun", underrun, 0);
      check("reset frame_error", ferr, 0);
      reset = 1'b0;
      wait_clk(6);

      for (int i = 0; i < 7; i++) begin
         mw[0] = vt[i].w0; mw[1] = vt[i].w1;
         em[0] = vt[i].m0; em[1] = vt[i].m1;
         frame_check($sformatf("vec%0d", i), vt[i].inst, vt[i].nw, vt[i].ld, vt[i].tx, vt[i].und);
      end

      // second load while not ready is dropped
      load(0, 12'h055);
      check("busy tx_ready", tx_ready[0], 0);
      load(0, 12'h066);
      check("busy tx_ready still", tx_ready[0], 0);
      mw[0] = 12'h001; mw[1] = 12'h002;
      em[0] = 12'h055; em[1] = 12'h010;
      frame_check("busy load", 0, 2, 1'b0, 12'h000, 1);

      // abort after 5 of 8 bits
      rb = rxv_cnt[0]; fb = fe_cnt[0];
      mw[0] = 12'h0FF;
      frame(0, 1, 5);
      check("abort frame_error count", fe_cnt[0] - fb, 1);
      check("abort rx_valid count", rxv_cnt[0] - rb, 0);
      mw[0] = 12'h05C; em[0] = 12'h010;
      frame_check("after abort", 0, 1, 1'b0, 12'h000, 1);

      // reset after 3 bits mid-frame
      ss_n[0] = 1'b0;
      wait_clk(8);
      for (int b = 0; b < 3; b++) xfer_bit(0, 1'b1, m);
      rb = rxv_cnt[0]; ub = und_cnt[0]; fb = fe_cnt[0];
      reset = 1'b1;
      wait_clk(2);
      check("midreset rx_data", rx_w[0], 0);
      check("midreset miso", miso[0], 0);
      check("midreset tx_ready", tx_ready[0], 1);
      ss_n[0] = 1'b1;
      wait_clk(4);
      reset = 1'b0;
      wait_clk(20);
      check("midreset rx_valid count", rxv_cnt[0] - rb, 0);
      check("midreset underrun count", und_cnt[0] - ub, 0);
      check("midreset frame_error count", fe_cnt[0] - fb, 0);
      mw[0] = 12'h03A; em[0] = 12'h010;
      frame_check("after reset", 0, 1, 1'b0, 12'h000, 1);

      // randomised frames against the word-level model
      for (int r = 0; r < 16; r++) begin
         k  = $urandom_range(0, 4);
         nw = $urandom_range(1, 3);
         ld = 1'($urandom_range(0, 1));
         tx = mask(k, 12'($urandom));
         for (int j = 0; j < 3; j++) begin
            mw[j] = mask(k, 12'($urandom));
            em[j] = (j == 0 && ld) ? tx : 12'h010;
         end
         frame_check($sformatf("rand%0d", r), k, nw, ld, tx, nw - int'(ld));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
